// File: rtl/sim_run_pkg.sv
// Shared types and constants for the simulation run controller.
// Holds the sequencer state encoding, the halt-cause codes and the
// default tohost store address used to signal end of test.
package sim_run_pkg;

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } run_state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_TOHOST  = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
    localparam logic [1:0] CAUSE_STALL   = 2'd3;

    localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_1000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous reset, synchronous clear and
// count enable. Once it reaches all-ones it holds there until cleared.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    // Count up on enable, stop at all-ones, clear has priority over enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller between the bench clock/reset and the CPU top.
// Stretches reset to the core, then counts run cycles and retires until
// a tohost store, a retire stall or the cycle budget ends the run, and
// latches the verdict as registered status outputs.
// Optional macro SIM_RUN_CTRL_LOOP_DETECT_EN adds self-loop detection
// (a retire whose PC repeats the previous retired PC halts with cause 3).
module sim_run_ctrl
    import sim_run_pkg::*;
#(
    parameter int               XLEN        = 32,
    parameter int               CNT_W       = 32,
    parameter int               RST_CYCLES  = 5,
    parameter int               MAX_CYCLES  = 1100,
    parameter int               STALL_LIMIT = 64,
    parameter logic [XLEN-1:0]  TOHOST_ADDR = DEFAULT_TOHOST_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              retire_valid,
    input  logic [XLEN-1:0]   retire_pc,
    input  logic              dmem_we,
    input  logic [XLEN-1:0]   dmem_addr,
    input  logic [XLEN-1:0]   dmem_wdata,
    output logic              core_rst,
    output logic              running,
    output logic              done,
    output logic              halt_pulse,
    output logic [1:0]        halt_cause,
    output logic              pass,
    output logic [XLEN-2:0]   fail_code,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instret_cnt
);

    localparam int HOLD_W  = $clog2(RST_CYCLES + 1);
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    run_state_t         state;
    run_state_t         state_d;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [STALL_W-1:0] stall_cnt;
    logic               in_hold;
    logic               in_run;
    logic               tohost_hit;
    logic               loop_hit;
    logic               stall_hit;
    logic               timeout_hit;
    logic               halt_det;
    logic [1:0]         cause_d;
    logic               pass_d;
    logic [XLEN-2:0]    fail_d;

    assign in_hold = (state == S_HOLD);
    assign in_run  = (state == S_RUN);

    assign core_rst = in_hold;
    assign running  = in_run;
    assign done     = (state == S_HALT);

    sat_counter #(.W(HOLD_W)) u_hold_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .en    (in_hold),
        .count (hold_cnt)
    );

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .en    (in_run),
        .count (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_instret_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .en    (in_run && retire_valid),
        .count (instret_cnt)
    );

    sat_counter #(.W(STALL_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (in_run && retire_valid),
        .en    (in_run && !retire_valid),
        .count (stall_cnt)
    );

    assign tohost_hit  = in_run && dmem_we && (dmem_addr == TOHOST_ADDR) && dmem_wdata[0];
    assign stall_hit   = in_run && !retire_valid && (stall_cnt == STALL_W'(STALL_LIMIT - 1));
    assign timeout_hit = in_run && (cycle_cnt == CNT_W'(MAX_CYCLES - 1));

`ifdef SIM_RUN_CTRL_LOOP_DETECT_EN
    logic [XLEN-1:0] prev_pc;

    // Remember the last retired PC so a `j .` self-loop is spotted on its second retire
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_pc <= '1;
        end else if (in_run && retire_valid) begin
            prev_pc <= retire_pc;
        end
    end

    assign loop_hit = in_run && retire_valid && (retire_pc == prev_pc);
`else
    logic unused_retire_pc;

    assign unused_retire_pc = ^retire_pc;
    assign loop_hit         = 1'b0;
`endif

    // Sequencer state register; reset lands in the hold state from anywhere
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_HOLD;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and verdict selection; tohost beats loop beats stall beats timeout
    always_comb begin
        state_d  = state;
        halt_det = 1'b0;
        cause_d  = CAUSE_NONE;
        pass_d   = 1'b0;
        fail_d   = '0;
        case (state)
            S_HOLD: begin
                if (hold_cnt == HOLD_W'(RST_CYCLES - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (tohost_hit) begin
                    halt_det = 1'b1;
                    cause_d  = CAUSE_TOHOST;
                    pass_d   = (dmem_wdata[XLEN-1:1] == '0);
                    fail_d   = dmem_wdata[XLEN-1:1];
                end else if (loop_hit || stall_hit) begin
                    halt_det = 1'b1;
                    cause_d  = CAUSE_STALL;
                end else if (timeout_hit) begin
                    halt_det = 1'b1;
                    cause_d  = CAUSE_TIMEOUT;
                end
                if (halt_det) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HOLD;
            end
        endcase
    end

    // Latch the verdict on the halt edge and pulse for the first halted cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_pulse <= 1'b0;
            halt_cause <= CAUSE_NONE;
            pass       <= 1'b0;
            fail_code  <= '0;
        end else begin
            halt_pulse <= halt_det;
            if (halt_det) begin
                halt_cause <= cause_d;
                pass       <= pass_d;
                fail_code  <= fail_d;
            end
        end
    end

endmodule
